// File: rtl/sd_img_writer_if.sv
// Bundle between the pixel source / SD operation engine and sd_img_writer.
// The writer sits on the slave side: it sinks pixels, raises write requests
// and serves block bytes back to the controller's read port.
interface sd_img_writer_if;
    // Frame control
    logic        frame_start;
    logic [31:0] base_addr;
    logic        busy;
    logic        frame_done;
    // Pixel stream
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    // SD controller side
    logic        sd_wr_req;
    logic [31:0] sd_wr_addr;
    logic        sd_wr_done;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;

    modport master (
        output frame_start, base_addr, pix_data, pix_valid, sd_wr_done, rd_en, rd_addr,
        input  busy, frame_done, pix_ready, sd_wr_req, sd_wr_addr, rd_data
    );

    modport slave (
        input  frame_start, base_addr, pix_data, pix_valid, sd_wr_done, rd_en, rd_addr,
        output busy, frame_done, pix_ready, sd_wr_req, sd_wr_addr, rd_data
    );
endinterface

// File: rtl/sd_img_writer.sv
// Packs a 16-bit pixel stream into 512-byte SD blocks through a ping-pong
// buffer and drives one single-block write per filled bank. Fill and drain
// run concurrently on opposite banks.
module sd_img_writer #(
    parameter int FRAME_PIXELS  = 786432,
    parameter int BLOCK_BYTES   = 512,
    parameter int PIX_PER_BLOCK = BLOCK_BYTES / 2
) (
    input  logic           clk,
    input  logic           rst,
    sd_img_writer_if.slave bus
);
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam int LW = $clog2(BLOCK_BYTES + 1);
    localparam int KW = $clog2(PIX_PER_BLOCK);
    localparam logic [CW-1:0] PIX_TOTAL = CW'(FRAME_PIXELS);
    localparam logic [CW-1:0] PIX_LAST  = CW'(FRAME_PIXELS - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(PIX_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Per-bank bookkeeping; level is the number of valid bytes in the bank.
    typedef struct packed {
        logic          full;
        logic          last;
        logic [LW-1:0] level;
    } bank_t;

    state_t        state;
    bank_t [1:0]   bank;
    logic [CW-1:0] pix_cnt;
    logic [KW-1:0] fill_k;
    logic          wr_bank;
    logic          rd_bank;
    logic [31:0]   blk_addr;

    // One 16-bit word per pixel: even byte address = high byte.
    logic [15:0]   mem [0:2*PIX_PER_BLOCK-1];
    logic [15:0]   rd_word;
    logic          acc;
    logic          last_pix;
    logic          blk_end;

    assign bus.pix_ready = bus.busy & (pix_cnt < PIX_TOTAL) & ~bank[wr_bank].full;
    assign acc           = bus.pix_valid & bus.pix_ready;
    assign last_pix      = (pix_cnt == PIX_LAST);
    assign blk_end       = (fill_k == K_LAST) | last_pix;
    assign rd_word       = mem[{rd_bank, bus.rd_addr[8:1]}];

    // Fill-side write port of the dual-port buffer.
    always_ff @(posedge clk) begin
        if (acc)
            mem[{wr_bank, fill_k}] <= bus.pix_data;
    end

    // Drain-side read port: registered byte, zero past a short block's fill level.
    always_ff @(posedge clk) begin
        if (rst)
            bus.rd_data <= 8'h00;
        else if (bus.rd_en) begin
            if (LW'(bus.rd_addr) < bank[rd_bank].level)
                bus.rd_data <= bus.rd_addr[0] ? rd_word[7:0] : rd_word[15:8];
            else
                bus.rd_data <= 8'h00;
        end
    end

    // Frame control, bank fill bookkeeping and the drain FSM share the bank state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bank           <= '0;
            pix_cnt        <= '0;
            fill_k         <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            blk_addr       <= '0;
            bus.busy       <= 1'b0;
            bus.sd_wr_req  <= 1'b0;
            bus.sd_wr_addr <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.sd_wr_req  <= 1'b0;
            bus.frame_done <= 1'b0;

            // rd_bank is realigned too, otherwise a frame with an odd block
            // count would leave the drain waiting on the wrong bank.
            if (bus.frame_start && !bus.busy) begin
                blk_addr <= bus.base_addr;
                pix_cnt  <= '0;
                fill_k   <= '0;
                wr_bank  <= 1'b0;
                rd_bank  <= 1'b0;
                bus.busy <= 1'b1;
            end

            if (acc) begin
                pix_cnt <= pix_cnt + CW'(1);
                if (blk_end) begin
                    bank[wr_bank].full  <= 1'b1;
                    bank[wr_bank].last  <= last_pix;
                    bank[wr_bank].level <= (LW'(fill_k) + LW'(1)) << 1;
                    wr_bank             <= ~wr_bank;
                    fill_k              <= '0;
                end else begin
                    fill_k <= fill_k + KW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (bank[rd_bank].full) begin
                        state          <= REQ;
                        bus.sd_wr_req  <= 1'b1;
                        bus.sd_wr_addr <= blk_addr;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (bus.sd_wr_done) begin
                        bank[rd_bank].full <= 1'b0;
                        rd_bank            <= ~rd_bank;
                        blk_addr           <= blk_addr + 32'd1;
                        state              <= IDLE;
                        if (bank[rd_bank].last) begin
                            bus.frame_done <= 1'b1;
                            bus.busy       <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_img_writer.sv
// Directed bench for sd_img_writer. Three instances with different frame
// sizes (512, 300, default) share the stimulus; sel picks which one is
// driven and observed, the others see their strobes held low.
module tb_sd_img_writer;
    localparam int FULL = 786432;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        frame_start, pix_valid, sd_wr_done, rd_en;
    logic [31:0] base_addr;
    logic [15:0] pix_data;
    logic [8:0]  rd_addr;

    logic [2:0]  req_v, fd_v, rdy_v, busy_v;
    logic [31:0] addr_v [3];
    logic [7:0]  rdat_v [3];
    logic        cur_req, cur_fd, cur_rdy, cur_busy;
    logic [31:0] cur_addr;
    logic [7:0]  cur_rdat;

    int          n_chk = 0;
    int          n_fail = 0;
    int          req_cnt = 0;
    int          fd_cnt = 0;
    logic [31:0] req_addr [64];
    logic [7:0]  rb [2][512];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sd_img_writer_if bus ();
        assign bus.frame_start = frame_start & (sel == 2'(g));
        assign bus.pix_valid   = pix_valid & (sel == 2'(g));
        assign bus.sd_wr_done  = sd_wr_done & (sel == 2'(g));
        assign bus.rd_en       = rd_en & (sel == 2'(g));
        assign bus.base_addr   = base_addr;
        assign bus.pix_data    = pix_data;
        assign bus.rd_addr     = rd_addr;
        assign req_v[g]        = bus.sd_wr_req;
        assign fd_v[g]         = bus.frame_done;
        assign rdy_v[g]        = bus.pix_ready;
        assign busy_v[g]       = bus.busy;
        assign addr_v[g]       = bus.sd_wr_addr;
        assign rdat_v[g]       = bus.rd_data;
        sd_img_writer #(.FRAME_PIXELS(g == 0 ? 512 : (g == 1 ? 300 : FULL))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    always_comb begin
        cur_req = 1'b0; cur_fd = 1'b0; cur_rdy = 1'b0; cur_busy = 1'b0;
        cur_addr = '0; cur_rdat = '0;
        case (sel)
            2'd0: begin cur_req = req_v[0]; cur_fd = fd_v[0]; cur_rdy = rdy_v[0]; cur_busy = busy_v[0]; cur_addr = addr_v[0]; cur_rdat = rdat_v[0]; end
            2'd1: begin cur_req = req_v[1]; cur_fd = fd_v[1]; cur_rdy = rdy_v[1]; cur_busy = busy_v[1]; cur_addr = addr_v[1]; cur_rdat = rdat_v[1]; end
            2'd2: begin cur_req = req_v[2]; cur_fd = fd_v[2]; cur_rdy = rdy_v[2]; cur_busy = busy_v[2]; cur_addr = addr_v[2]; cur_rdat = rdat_v[2]; end
            default: ;
        endcase
    end

    // Request / frame_done monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (cur_req) begin
            if (req_cnt < 64) req_addr[req_cnt] = cur_addr;
            req_cnt++;
        end
        if (cur_fd) fd_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(int blk, int a, int n, logic [15:0] mask);
        int p;
        logic [15:0] v;
        p = blk * 256 + a / 2;
        if (p >= n) return 8'h00;
        v = 16'(p) ^ mask;
        return a[0] ? v[7:0] : v[15:8];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [31:0] base);
        @(negedge clk); base_addr = base; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic send_pixels(input int from, input int to, input logic [15:0] mask);
        int idx = from;
        int cyc = 0;
        while (idx < to && cyc < 5000) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = 16'(idx) ^ mask;
            if (cur_rdy) idx++;
            cyc++;
        end
        chk("send_all", idx, to);
        @(negedge clk); pix_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int cyc = 0;
        while (!cur_req && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, cur_req, 1'b1);
    endtask

    task automatic read_block(input int slot, input int blk, input int n, input logic [15:0] mask);
        int errs = 0;
        for (int a = 0; a <= 512; a++) begin
            @(negedge clk);
            if (a > 0) begin
                rb[slot][a-1] = cur_rdat;
                if (cur_rdat !== exp_byte(blk, a - 1, n, mask)) errs++;
            end
            if (a < 512) begin rd_en = 1'b1; rd_addr = 9'(a); end
            else rd_en = 1'b0;
        end
        chk($sformatf("blk%0d_bad_bytes", blk), errs, 0);
    endtask

    task automatic done_pulse();
        @(negedge clk); sd_wr_done = 1'b1;
        @(negedge clk); sd_wr_done = 1'b0;
    endtask

    task automatic serve(input int slot, input int blk, input int n, input logic [15:0] mask);
        wait_req($sformatf("blk%0d_req_seen", blk));
        read_block(slot, blk, n, mask);
        done_pulse();
    endtask

    initial begin
        int r0, f0, acc;
        sel = 2'd0; rst = 1'b1; pix_valid = 1'b1; pix_data = 16'hBEEF;
        frame_start = 1'b0; sd_wr_done = 1'b0; rd_en = 1'b0;
        base_addr = '0; rd_addr = '0;

        // Reset held 3 cycles with pix_valid high
        tick(3);
        chk("rst_pix_ready", cur_rdy, 1'b0);
        chk("rst_sd_wr_req", cur_req, 1'b0);
        chk("rst_sd_wr_addr", cur_addr, 32'h0);
        chk("rst_rd_data", cur_rdat, 8'h00);
        chk("rst_busy", cur_busy, 1'b0);
        chk("rst_frame_done", cur_fd, 1'b0);
        r0 = req_cnt;
        rst = 1'b0;
        tick(20);
        chk("idle_no_req", req_cnt - r0, 0);
        chk("idle_ready_low", cur_rdy, 1'b0);
        pix_valid = 1'b0;

        // 512-pixel frame at 0x1000
        r0 = req_cnt; f0 = fd_cnt;
        start_frame(32'h1000);
        chk("f512_busy", cur_busy, 1'b1);
        fork
            send_pixels(0, 512, 16'h0);
            begin
                serve(0, 0, 512, 16'h0);
                chk("f512_no_early_done", fd_cnt - f0, 0);
                serve(1, 1, 512, 16'h0);
            end
        join
        tick(3);
        chk("f512_req_cnt", req_cnt - r0, 2);
        chk("f512_addr0", req_addr[r0], 32'h1000);
        chk("f512_addr1", req_addr[r0+1], 32'h1001);
        chk("f512_b0_byte0", rb[0][0], 8'h00);
        chk("f512_b0_byte1", rb[0][1], 8'h00);
        chk("f512_b0_byte2", rb[0][2], 8'h00);
        chk("f512_b0_byte3", rb[0][3], 8'h01);
        chk("f512_b0_byte511", rb[0][511], 8'hFF);
        chk("f512_b1_byte0", rb[1][0], 8'h01);
        chk("f512_frame_done", fd_cnt - f0, 1);
        chk("f512_busy_end", cur_busy, 1'b0);

        // Ignored frame_start while busy, spurious sd_wr_done in IDLE
        r0 = req_cnt; f0 = fd_cnt;
        start_frame(32'h2000);
        send_pixels(0, 10, 16'h0);
        done_pulse();
        start_frame(32'h3000);
        fork
            send_pixels(10, 512, 16'h0);
            begin
                serve(0, 0, 512, 16'h0);
                serve(1, 1, 512, 16'h0);
            end
        join
        tick(3);
        chk("ign_req_cnt", req_cnt - r0, 2);
        chk("ign_addr0", req_addr[r0], 32'h2000);
        chk("ign_addr1", req_addr[r0+1], 32'h2001);
        chk("ign_frame_done", fd_cnt - f0, 1);
        chk("ign_busy_end", cur_busy, 1'b0);

        // 300-pixel frame: short second block
        sel = 2'd1;
        r0 = req_cnt; f0 = fd_cnt;
        start_frame(32'h40);
        fork
            send_pixels(0, 300, 16'h0);
            begin
                serve(0, 0, 300, 16'h0);
                serve(1, 1, 300, 16'h0);
            end
        join
        tick(3);
        chk("f300_req_cnt", req_cnt - r0, 2);
        chk("f300_addr1", req_addr[r0+1], 32'h41);
        chk("f300_b1_byte0", rb[1][0], 8'h01);
        chk("f300_b1_byte86", rb[1][86], 8'h01);
        chk("f300_b1_byte87", rb[1][87], 8'h2B);
        chk("f300_b1_byte88", rb[1][88], 8'h00);
        chk("f300_b1_byte511", rb[1][511], 8'h00);
        chk("f300_frame_done", fd_cnt - f0, 1);
        chk("f300_busy_end", cur_busy, 1'b0);

        // Backpressure on the full-size frame: no sd_wr_done until both banks fill
        sel = 2'd2;
        r0 = req_cnt;
        start_frame(32'h0);
        acc = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = 16'(acc);
            if (cur_rdy) acc++;
        end
        chk("bp_accepted", acc, 512);
        chk("bp_ready_low", cur_rdy, 1'b0);
        chk("bp_req_cnt", req_cnt - r0, 1);
        chk("bp_addr0", req_addr[r0], 32'h0);
        read_block(0, 0, FULL, 16'h0);
        @(negedge clk); sd_wr_done = 1'b1;
        chk("bp_ready_still_low", cur_rdy, 1'b0);
        @(negedge clk); sd_wr_done = 1'b0; pix_valid = 1'b0;
        chk("bp_ready_rise", cur_rdy, 1'b1);
        fork
            send_pixels(512, 768, 16'h0);
            begin
                serve(1, 1, FULL, 16'h0);
                wait_req("blk2_req_seen");
                read_block(0, 2, FULL, 16'h0);
            end
        join
        chk("bp_addr1", req_addr[r0+1], 32'h1);
        chk("bp_addr2", req_addr[r0+2], 32'h2);

        // Reset mid-read in WAIT, then a fresh frame at 0x20
        @(negedge clk); rd_en = 1'b1; rd_addr = 9'd5;
        @(negedge clk); rd_addr = 9'd6; rst = 1'b1;
        @(negedge clk); rst = 1'b0; rd_en = 1'b0;
        r0 = req_cnt;
        chk("mid_rst_busy", cur_busy, 1'b0);
        chk("mid_rst_addr", cur_addr, 32'h0);
        chk("mid_rst_rd_data", cur_rdat, 8'h00);
        tick(20);
        chk("mid_rst_no_req", req_cnt - r0, 0);
        start_frame(32'h20);
        fork
            send_pixels(0, 256, 16'h5A3C);
            serve(0, 0, FULL, 16'h5A3C);
        join
        chk("new_req_cnt", req_cnt - r0, 1);
        chk("new_addr0", req_addr[r0], 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
